// File: rtl/chroma_lock_ctrl.sv
// Colour-burst lock sequencer: gates the burst window per line, grades each line
// and drives PLL acquire/track gains, lock status and colour kill.
//
// line state | meaning
// NOSYNC     | no hsync edge seen recently; waiting for the first edge
// WAIT       | edge seen, counting up to the burst window
// BURST      | burst gate open, tracking peak phase error and amplitude
// EVAL       | one-cycle line grading, line_strobe high
// IDLE       | line graded, waiting for the next edge
// lock state | meaning
// ACQUIRE    | wide gains, searching for lock
// TRACK      | narrow gains, locked
module chroma_lock_ctrl #(
  parameter int BURST_START  = 40,
  parameter int BURST_LEN    = 20,
  parameter int LOCK_THRESH  = 64,
  parameter int LOCK_LINES   = 8,
  parameter int UNLOCK_LINES = 3,
  parameter int MIN_AMP      = 128,
  parameter int LINE_TIMEOUT = 6000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync_in,
  input  logic signed [11:0] phase_error,
  input  logic        [11:0] burst_amp,
  output logic               burst_active,
  output logic               gain_sel,
  output logic               filter_clear,
  output logic               locked,
  output logic               color_kill,
  output logic               line_strobe
);

  localparam int CW = $clog2(LINE_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int BW = $clog2(UNLOCK_LINES + 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(LINE_TIMEOUT);
  localparam logic [CW-1:0] CNT_TO    = CW'(LINE_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_BURST = CW'(BURST_START - 1);
  localparam logic [CW-1:0] CNT_EVAL  = CW'(BURST_START + BURST_LEN - 1);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_LINES);
  localparam logic [BW-1:0] BAD_MAX   = BW'(UNLOCK_LINES);

  typedef enum logic [2:0] {S_NOSYNC, S_WAIT, S_BURST, S_EVAL, S_IDLE} line_t;
  typedef enum logic {L_ACQUIRE, L_TRACK} lock_t;

  line_t          line_st;
  lock_t          lock_st;
  logic           hs_q, hs_d, pend_edge;
  logic [CW-1:0]  line_cnt;
  logic [10:0]    err_max, err_abs;
  logic [11:0]    amp_max, neg_err;
  logic [GW-1:0]  good_cnt, good_nxt;
  logic [BW-1:0]  bad_cnt, bad_nxt, low_cnt, low_nxt;
  logic           hs_edge, timeout, amp_ok, good;

  assign hs_edge = hs_q & ~hs_d;
  assign timeout = (line_cnt == CNT_TO) && (line_st != S_NOSYNC);
  assign neg_err = 12'(-phase_error);

  always_comb begin
    err_abs = phase_error[10:0];
    // -2048 has no positive 12-bit twin, so it saturates to 2047
    if (phase_error[11])
      err_abs = (phase_error == -12'sd2048) ? 11'h7ff : neg_err[10:0];
    amp_ok   = amp_max >= 12'(MIN_AMP);
    good     = amp_ok && (err_max <= 11'(LOCK_THRESH));
    good_nxt = '0;
    bad_nxt  = '0;
    low_nxt  = '0;
    if (good) good_nxt = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
    else      bad_nxt  = (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + BW'(1);
    if (!amp_ok) low_nxt = (low_cnt == BAD_MAX) ? low_cnt : low_cnt + BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_st      <= S_NOSYNC;
      lock_st      <= L_ACQUIRE;
      hs_q         <= 1'b0;
      hs_d         <= 1'b0;
      pend_edge    <= 1'b0;
      line_cnt     <= '0;
      err_max      <= '0;
      amp_max      <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      low_cnt      <= '0;
      burst_active <= 1'b0;
      gain_sel     <= 1'b1;
      filter_clear <= 1'b0;
      locked       <= 1'b0;
      color_kill   <= 1'b1;
      line_strobe  <= 1'b0;
    end else begin
      hs_q         <= hsync_in;
      hs_d         <= hs_q;
      filter_clear <= 1'b0;
      line_strobe  <= 1'b0;
      pend_edge    <= 1'b0;
      if (line_cnt != CNT_SAT) line_cnt <= line_cnt + CW'(1);

      if (timeout) begin
        // an edge landing on the timeout cycle is replayed one cycle later
        line_st      <= S_NOSYNC;
        lock_st      <= L_ACQUIRE;
        pend_edge    <= hs_edge;
        burst_active <= 1'b0;
        locked       <= 1'b0;
        gain_sel     <= 1'b1;
        good_cnt     <= '0;
        bad_cnt      <= '0;
        low_cnt      <= '0;
        filter_clear <= 1'b1;
        color_kill   <= 1'b1;
      end else begin
        if (line_st == S_EVAL) begin
          good_cnt <= good_nxt;
          bad_cnt  <= bad_nxt;
          low_cnt  <= low_nxt;
          if (lock_st == L_ACQUIRE && good_nxt == GOOD_MAX) begin
            lock_st  <= L_TRACK;
            locked   <= 1'b1;
            gain_sel <= 1'b0;
          end else if (lock_st == L_TRACK && bad_nxt == BAD_MAX) begin
            lock_st      <= L_ACQUIRE;
            locked       <= 1'b0;
            gain_sel     <= 1'b1;
            filter_clear <= 1'b1;
          end
          if (low_nxt == BAD_MAX) color_kill <= 1'b1;
          else if (amp_ok)        color_kill <= 1'b0;
        end

        unique case (line_st)
          S_NOSYNC: if (hs_edge || pend_edge) begin
            line_st  <= S_WAIT;
            line_cnt <= CW'(1);
          end
          S_WAIT: begin
            if (hs_edge) begin
              line_cnt <= CW'(1);
            end else if (line_cnt == CNT_BURST) begin
              line_st      <= S_BURST;
              burst_active <= 1'b1;
              err_max      <= '0;
              amp_max      <= '0;
            end
          end
          S_BURST: begin
            if (hs_edge) begin
              line_st      <= S_WAIT;
              burst_active <= 1'b0;
              line_cnt     <= CW'(1);
            end else begin
              if (err_abs > err_max)   err_max <= err_abs;
              if (burst_amp > amp_max) amp_max <= burst_amp;
              if (line_cnt == CNT_EVAL) begin
                line_st      <= S_EVAL;
                burst_active <= 1'b0;
                line_strobe  <= 1'b1;
              end
            end
          end
          S_EVAL, S_IDLE: begin
            if (hs_edge) begin
              line_st  <= S_WAIT;
              line_cnt <= CW'(1);
            end else begin
              line_st <= S_IDLE;
            end
          end
          default: line_st <= S_NOSYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chroma_lock_ctrl.sv
// Bench for chroma_lock_ctrl: directed lines push expected post-EVAL status into a
// queue; a negedge monitor pops one entry per line_strobe and checks burst timing.
module tb_chroma_lock_ctrl;

  logic               clk = 1'b0;
  logic               rst_n, hsync_in;
  logic signed [11:0] phase_error;
  logic        [11:0] burst_amp;
  logic               burst_active, gain_sel, filter_clear, locked, color_kill, line_strobe;

  chroma_lock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .phase_error(phase_error),
    .burst_amp(burst_amp), .burst_active(burst_active), .gain_sel(gain_sel),
    .filter_clear(filter_clear), .locked(locked), .color_kill(color_kill),
    .line_strobe(line_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lck;
    logic gain;
    logic kill;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor state
  logic hs_prev = 1'b0, ba_prev = 1'b0, post_pending = 1'b0;
  int   last_edge = 0, burst_start_off = 0, cur_run = 0, last_run = 0;
  int   burst_total = 0, fc_cnt = 0;
  exp_t cur;

  always @(negedge clk) begin
    // DUT sees a rise of hsync_in as an edge one cycle later
    if (hsync_in && !hs_prev) last_edge = cyc + 1;
    hs_prev = hsync_in;
    if (burst_active) begin
      if (!ba_prev) begin
        burst_start_off = cyc - last_edge;
        cur_run = 0;
      end
      cur_run++;
      burst_total++;
    end else if (ba_prev) begin
      last_run = cur_run;
    end
    ba_prev = burst_active;
    if (filter_clear) fc_cnt++;
    if (post_pending) begin
      chk("locked_after_eval", locked, cur.lck);
      chk("gain_after_eval", gain_sel, cur.gain);
      chk("kill_after_eval", color_kill, cur.kill);
      post_pending = 1'b0;
    end
    if (line_strobe) begin
      if (q.size() == 0) begin
        chk("unexpected_line_strobe", 1, 0);
      end else begin
        cur = q.pop_front();
        chk("strobe_offset", cyc - last_edge, 60);
        chk("burst_start_offset", burst_start_off, 40);
        chk("burst_length", last_run, 20);
        post_pending = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_line(input logic l, input logic g, input logic k);
    exp_t e;
    e.lck = l; e.gain = g; e.kill = k;
    q.push_back(e);
  endtask

  task automatic run_line(input int period, input logic signed [11:0] err,
                          input logic [11:0] amp, input logic l, input logic g,
                          input logic k);
    phase_error = err;
    burst_amp   = amp;
    expect_line(l, g, k);
    hsync_in = 1'b1;
    tick(5);
    hsync_in = 1'b0;
    tick(period - 5);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_burst_active"}, burst_active, 0);
    chk({tag, "_gain_sel"}, gain_sel, 1);
    chk({tag, "_filter_clear"}, filter_clear, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_color_kill"}, color_kill, 1);
    chk({tag, "_line_strobe"}, line_strobe, 0);
  endtask

  int fc0, bt0;

  initial begin
    rst_n = 1'b0; hsync_in = 1'b0; phase_error = '0; burst_amp = '0;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // acquire: 8 good lines at 4719-cycle spacing
    for (int i = 1; i <= 8; i++)
      run_line(4719, 12'sd0, 12'd500, i == 8, i != 8, 1'b0);

    // two bad lines then a good one keep lock; three bad lines drop it
    fc0 = fc_cnt;
    run_line(300, 12'sd1000, 12'd500, 1, 0, 0);
    run_line(300, 12'sd1000, 12'd500, 1, 0, 0);
    run_line(300, 12'sd0,    12'd500, 1, 0, 0);
    chk("fc_while_lock_retained", fc_cnt - fc0, 0);
    run_line(300, 12'sd1000, 12'd500, 1, 0, 0);
    run_line(300, 12'sd1000, 12'd500, 1, 0, 0);
    run_line(300, 12'sd1000, 12'd500, 0, 1, 0);
    chk("fc_on_unlock", fc_cnt - fc0, 1);

    // low amplitude: colour kill after the third line, released by amp 200
    run_line(300, 12'sd0, 12'd50,  0, 1, 0);
    run_line(300, 12'sd0, 12'd50,  0, 1, 0);
    run_line(300, 12'sd0, 12'd50,  0, 1, 1);
    run_line(300, 12'sd0, 12'd200, 0, 1, 0);

    // amp-200 line counted as good, so 7 more reach lock; -2048 must read as large
    for (int i = 1; i <= 7; i++)
      run_line(300, 12'sd0, 12'd500, i == 7, i != 7, 1'b0);
    chk("locked_before_timeout", locked, 1);

    // hsync held low past the line timeout
    fc0 = fc_cnt;
    tick(6100);
    chk("timeout_locked", locked, 0);
    chk("timeout_gain_sel", gain_sel, 1);
    chk("timeout_color_kill", color_kill, 1);
    chk("timeout_burst_active", burst_active, 0);
    chk("timeout_fc_pulses", fc_cnt - fc0, 1);
    chk("timeout_good_cnt", dut.good_cnt, 0);

    // second edge 50 cycles after the first aborts the burst
    phase_error = 12'sd0; burst_amp = 12'd500;
    hsync_in = 1'b1; tick(5); hsync_in = 1'b0; tick(45);
    expect_line(0, 1, 0);
    hsync_in = 1'b1; tick(5); hsync_in = 1'b0; tick(10);
    // 10 cycles before the abort edge, plus the edge cycle itself
    chk("abort_burst_cycles", last_run, 11);
    chk("abort_good_cnt", dut.good_cnt, 0);
    tick(285);
    chk("after_abort_good_cnt", dut.good_cnt, 1);

    // large negative error gives a bad line
    run_line(300, -12'sd2048, 12'd500, 0, 1, 0);
    chk("neg_full_scale_good_cnt", dut.good_cnt, 0);

    // reset in the middle of a burst
    hsync_in = 1'b1; tick(5); hsync_in = 1'b0; tick(40);
    chk("mid_burst_active", burst_active, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    tick(3);
    rst_n = 1'b1;
    bt0 = burst_total;
    tick(200);
    chk("no_burst_after_reset", burst_total - bt0, 0);
    chk("idle_after_reset_kill", color_kill, 1);
    run_line(300, 12'sd0, 12'd500, 0, 1, 0);

    tick(10);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
